// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: RV32I width codes,
// FSM state encoding and the registered bus request payload.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;
  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } lsu_bus_req_t;

endpackage

// File: rtl/load_store_unit_lane_format.sv
// Byte-lane steering for stores, lane select plus sign/zero extension for
// loads, and alignment / funct3 legality decode.
module lsu_lane_format
  import load_store_unit_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            is_store,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rd_word,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] st_lanes,
  output logic [XLEN-1:0] ld_data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    be         = '0;
    st_lanes   = '0;
    ld_data    = '0;
    rd_byte    = rd_word[7:0];
    rd_half    = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    unique case (byte_off)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase

    // Half needs bit 0 clear, word needs both low bits clear.
    unique case (funct3[1:0])
      2'b01:   misaligned = byte_off[0];
      2'b10:   misaligned = (byte_off != 2'b00);
      default: misaligned = 1'b0;
    endcase

    if (is_store) begin
      illegal = (funct3 >= 3'b011);
      unique case (funct3)
        F3_SB: begin
          be       = BE_W'(4'b0001 << byte_off);
          st_lanes = {4{st_data[7:0]}};
        end
        F3_SH: begin
          be       = byte_off[1] ? 4'b1100 : 4'b0011;
          st_lanes = {2{st_data[15:0]}};
        end
        F3_SW: begin
          be       = 4'b1111;
          st_lanes = st_data;
        end
        default: begin
          be       = '0;
          st_lanes = '0;
        end
      endcase
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      be      = 4'b1111;
    end

    unique case (funct3)
      F3_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
      F3_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
      F3_LW:   ld_data = rd_word;
      F3_LBU:  ld_data = {24'h000000, rd_byte};
      F3_LHU:  ld_data = {16'h0000, rd_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per instruction over a req/gnt/rvalid
// bus, stalling the core while in flight, with misalignment and timeout handling.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              load_done,
  output logic              exc_misaligned,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e   state_q, state_d;
  lsu_bus_req_t req_q;
  logic [F3_W-1:0] f3_q;
  logic [1:0]   off_q;
  logic [CNT_W-1:0] cnt_q;
  logic         err_q;

  logic         in_idle, start, fault, accept, timeout;
  logic         cnt_clr, cnt_inc, ld_cap, to_abort;

  logic [F3_W-1:0] fmt_f3;
  logic         fmt_store;
  logic [1:0]   fmt_off;
  logic [BE_W-1:0] fmt_be;
  logic [XLEN-1:0] fmt_wdata, fmt_ld;
  logic         fmt_misaligned, fmt_illegal;

  assign in_idle = (state_q == S_IDLE);
  // rst_n gating keeps the combinational outputs quiet while reset is held.
  assign start   = rst_n & valid & (mem_read | mem_write) & in_idle;
  assign fault   = start & (fmt_misaligned | fmt_illegal);
  assign accept  = start & ~fault;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Live instruction fields decode in IDLE; the captured ones format the load reply.
  assign fmt_f3    = in_idle ? funct3    : f3_q;
  assign fmt_store = in_idle ? mem_write : req_q.we;
  assign fmt_off   = in_idle ? addr[1:0] : off_q;

  lsu_lane_format u_lane_format (
    .funct3     (fmt_f3),
    .is_store   (fmt_store),
    .byte_off   (fmt_off),
    .st_data    (wdata),
    .rd_word    (bus_rdata),
    .be         (fmt_be),
    .st_lanes   (fmt_wdata),
    .ld_data    (fmt_ld),
    .misaligned (fmt_misaligned),
    .illegal    (fmt_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    exc_misaligned = 1'b0;
    bus_req        = 1'b0;
    load_done      = 1'b0;
    bus_err        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    ld_cap         = 1'b0;
    to_abort       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        exc_misaligned = fault;
        if (accept) begin
          stall   = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        cnt_inc = 1'b1;
        // A grant on the last allowed cycle still aborts: no reply would be waited for.
        if (timeout) begin
          to_abort = 1'b1;
          state_d  = S_DONE;
        end else if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall   = 1'b1;
        cnt_inc = 1'b1;
        if (bus_rvalid) begin
          ld_cap  = ~req_q.we;
          state_d = S_DONE;
        end else if (timeout) begin
          to_abort = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        load_done = ~req_q.we & ~err_q;
        bus_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request payload captured once at acceptance and held until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      f3_q  <= '0;
      off_q <= '0;
    end else if (accept) begin
      req_q.we    <= mem_write;
      req_q.addr  <= {addr[31:2], 2'b00};
      req_q.be    <= fmt_be;
      req_q.wdata <= fmt_wdata;
      f3_q        <= funct3;
      off_q       <= addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (accept)   err_q <= 1'b0;
    else if (to_abort) err_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rdata <= '0;
    else if (ld_cap)   rdata <= fmt_ld;
    else if (to_abort) rdata <= '0;
  end

  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_be    = req_q.be;
  assign bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// requests and responses; a monitor pops and compares as the DUT presents them.
module tb_load_store_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_done, exc_misaligned, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .load_done(load_done),
    .exc_misaligned(exc_misaligned), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } req_exp_t;

  typedef struct {
    string       name;
    logic        ld;
    logic        err;
    logic        exc;
    logic [31:0] rdata;
  } resp_exp_t;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] held_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder: grant after gnt_dly REQ cycles, reply rv_dly cycles after grant.
  int          gnt_dly, rv_dly;
  bit          no_gnt;
  logic [31:0] rword;

  initial begin
    int  req_wait;
    int  rv_cnt;
    bit  rv_active;
    req_wait = 0; rv_cnt = 0; rv_active = 0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      if (!rst_n) begin
        req_wait = 0; rv_active = 0;
      end else begin
        if (rv_active) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rword;
            rv_active  = 0;
          end
        end
        if (bus_req && !no_gnt) begin
          if (req_wait == gnt_dly) begin
            bus_gnt   = 1'b1;
            req_wait  = 0;
            rv_active = 1;
            rv_cnt    = rv_dly;
          end else begin
            req_wait++;
          end
        end else begin
          req_wait = 0;
        end
      end
    end
  end

  // Monitor: compares granted requests and completion/exception events.
  initial begin
    bit stall_prev;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (bus_req && bus_gnt) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", 64'(bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            req_exp_t e;
            e = req_q.pop_front();
            check({e.name, "_req_we_addr_be"}, 64'({bus_we, bus_addr, bus_be}),
                  64'({e.we, e.addr, e.be}));
            if (e.chk_wdata) check({e.name, "_req_wdata"}, 64'(bus_wdata), 64'(e.wdata));
          end
        end
        if (exc_misaligned || (stall_prev && !stall)) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", 64'({load_done, bus_err, exc_misaligned, rdata}), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            resp_exp_t r;
            r = resp_q.pop_front();
            check({r.name, "_resp_ld_err_exc_rdata"},
                  64'({load_done, bus_err, exc_misaligned, rdata}),
                  64'({r.ld, r.err, r.exc, r.rdata}));
          end
        end
        stall_prev = stall;
      end
    end
  end

  task automatic do_access(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rd, input bit ng, input logic [31:0] rw,
                           input bit exp_fault, input bit exp_err,
                           input logic [3:0] exp_be, input logic [31:0] exp_bwd,
                           input logic [31:0] exp_rd, input int exp_stall, input int exp_reqc);
    req_exp_t  rq;
    resp_exp_t rs;
    int sc, rc;
    bit done, seen;
    if (!exp_fault) begin
      rq.name = name; rq.we = st; rq.addr = {a[31:2], 2'b00};
      rq.be = exp_be; rq.wdata = exp_bwd; rq.chk_wdata = st;
      if (!ng) req_q.push_back(rq);
    end
    rs.name = name; rs.ld = 0; rs.err = 0; rs.exc = 0; rs.rdata = held_rd;
    if (exp_fault) rs.exc = 1;
    else if (exp_err) begin rs.err = 1; rs.rdata = '0; end
    else if (!st) begin rs.ld = 1; rs.rdata = exp_rd; end
    held_rd = rs.rdata;
    resp_q.push_back(rs);

    @(posedge clk); #1;
    gnt_dly = gd; rv_dly = rd; no_gnt = ng; rword = rw;
    valid = 1'b1; mem_read = ~st; mem_write = st; funct3 = f3; addr = a; wdata = wd;
    sc = 0; rc = 0; done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin done = 1; break; end
      sc++;
      if (bus_req) rc++;
    end
    check({name, "_completes"}, 64'(done), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_req) seen = 1;
    end
    check({name, "_idle_after"}, 64'(seen), 64'd0);
    if (exp_stall >= 0) check({name, "_stall_cycles"}, 64'(sc), 64'(exp_stall));
    if (exp_reqc >= 0)  check({name, "_req_cycles"}, 64'(rc), 64'(exp_reqc));
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    gnt_dly = 0; rv_dly = 1; no_gnt = 0; rword = '0; held_rd = '0;
    #2;
    check("reset_outputs",
          64'({stall, load_done, exc_misaligned, bus_err, bus_req, bus_we, bus_be}), 64'd0);
    check("reset_data", 64'({bus_addr, rdata}), 64'd0);
    check("reset_bus_wdata", 64'(bus_wdata), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //         name        st f3     addr          wdata         gd rd ng rword        flt err be       bwd           rdata         stall reqc
    do_access("lw_basic",  0, 3'b010, 32'h0000_0100, 32'h0,       0, 2, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,       32'hDEADBEEF, 4,  1);
    do_access("lb_neg",    0, 3'b000, 32'h0000_0103, 32'h0,       0, 1, 0, 32'h80FF0000, 0, 0, 4'b1111, 32'h0,       32'hFFFFFF80, 3,  1);
    do_access("lbu",       0, 3'b100, 32'h0000_0103, 32'h0,       0, 1, 0, 32'h80FF0000, 0, 0, 4'b1111, 32'h0,       32'h00000080, 3,  1);
    do_access("lh_neg",    0, 3'b001, 32'h0000_0102, 32'h0,       0, 1, 0, 32'h80FF0000, 0, 0, 4'b1111, 32'h0,       32'hFFFF80FF, 3,  1);
    do_access("lhu",       0, 3'b101, 32'h0000_0102, 32'h0,       0, 1, 0, 32'h80FF0000, 0, 0, 4'b1111, 32'h0,       32'h000080FF, 3,  1);
    do_access("sb",        1, 3'b000, 32'h0000_0201, 32'h000000A5, 0, 1, 0, 32'h0,       0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0,       3,  1);
    do_access("sh_hi",     1, 3'b001, 32'h0000_0302, 32'h1234BEEF, 0, 1, 0, 32'h0,       0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0,       3,  1);
    do_access("sw",        1, 3'b010, 32'h0000_0404, 32'hCAFEF00D, 0, 1, 0, 32'h0,       0, 0, 4'b1111, 32'hCAFEF00D, 32'h0,       3,  1);
    do_access("lw_misal",  0, 3'b010, 32'h0000_0102, 32'h0,       0, 1, 0, 32'h0,       1, 0, 4'b0000, 32'h0,       32'h0,       0,  0);
    do_access("sh_misal",  1, 3'b001, 32'h0000_0301, 32'h0,       0, 1, 0, 32'h0,       1, 0, 4'b0000, 32'h0,       32'h0,       0,  0);
    do_access("ld_f3_011", 0, 3'b011, 32'h0000_0100, 32'h0,       0, 1, 0, 32'h0,       1, 0, 4'b0000, 32'h0,       32'h0,       0,  0);
    do_access("st_f3_100", 1, 3'b100, 32'h0000_0100, 32'h0,       0, 1, 0, 32'h0,       1, 0, 4'b0000, 32'h0,       32'h0,       0,  0);
    do_access("to_nognt",  0, 3'b010, 32'h0000_0100, 32'h0,       0, 1, 1, 32'h0,       0, 1, 4'b1111, 32'h0,       32'h0,       9,  TO);
    do_access("lw_rv_tie", 0, 3'b010, 32'h0000_0108, 32'h0,       0, 7, 0, 32'h12345678, 0, 0, 4'b1111, 32'h0,       32'h12345678, 9,  1);
    do_access("to_wait",   0, 3'b010, 32'h0000_0108, 32'h0,       0, 8, 0, 32'h55555555, 0, 1, 4'b1111, 32'h0,       32'h0,       9,  1);
    do_access("lw_gnt3",   0, 3'b010, 32'h0000_010C, 32'h0,       3, 1, 0, 32'h0BADF00D, 0, 0, 4'b1111, 32'h0,       32'h0BADF00D, 6,  4);

    // Reset asserted while the load waits for its reply.
    begin
      req_exp_t rq;
      rq.name = "rst_abort"; rq.we = 0; rq.addr = 32'h0000_0100;
      rq.be = 4'b1111; rq.wdata = '0; rq.chk_wdata = 0;
      req_q.push_back(rq);
      @(posedge clk); #1;
      gnt_dly = 0; rv_dly = 20; no_gnt = 0; rword = 32'h11111111;
      valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
      @(posedge clk); @(posedge clk); #3;
      check("rst_in_wait_stall", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_drop_req_stall", 64'({bus_req, stall}), 64'd0);
      check("rst_clear_rdata", 64'(rdata), 64'd0);
      held_rd = '0;
      valid = 1'b0; mem_read = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
    do_access("lw_post_rst", 0, 3'b010, 32'h0000_0100, 32'h0, 0, 2, 0, 32'h5A5A5A5A, 0, 0, 4'b1111, 32'h0, 32'h5A5A5A5A, 4, 1);

    repeat (5) @(posedge clk);
    check("queues_drained", 64'(req_q.size() + resp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
